// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: NOP encoding, PC step and FSM states.
package fetch_pkg;

  // Instruction shown to decode whenever the buffer has nothing valid to offer.
  localparam logic [15:0] NOP_INST = 16'h0800;

  // Fixed instruction size in address units.
  localparam int PC_INC = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_buf_if.sv
// Instruction-memory read port plus the decode-side valid/ready handshake.
interface fetch_prefetch_buf_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] imem_addr;
  logic             imem_rd;
  logic [WIDTH-1:0] imem_rdata;
  logic             imem_done;
  logic             imem_err;

  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_inst;
  logic [WIDTH-1:0] deq_inc_pc;

  // Fetch unit side: drives the read request and the decode-facing head entry.
  modport master (
    output imem_addr, imem_rd, deq_valid, deq_inst, deq_inc_pc,
    input  imem_rdata, imem_done, imem_err, deq_ready
  );

  // Environment side: memory responder and decode consumer.
  modport slave (
    input  imem_addr, imem_rd, deq_valid, deq_inst, deq_inc_pc,
    output imem_rdata, imem_done, imem_err, deq_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small register FIFO holding {instruction, pc+2} pairs; head is readable combinationally.
module fetch_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer/count next state; a flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_prefetch_buf.sv
// Fetch front end: owns the PC, issues instruction reads, buffers results for decode.
module fetch_prefetch_buf
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(NOP_INST),
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [WIDTH-1:0]   redirect_pc,
  input  logic               halt,
  fetch_prefetch_buf_if.master bus,
  output logic [CW-1:0]      occupancy,
  output logic               err
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] drop_addr_q, drop_addr_d;

  logic             redirect_eff;
  logic             credit;
  logic             push;
  logic             pop;
  logic             deq_valid;
  logic             rd;
  logic [WIDTH-1:0] addr;
  logic [CW-1:0]    count;
  logic [CW:0]      count_after;
  logic [2*WIDTH-1:0] head_data;

  // Once in ERR the unit is frozen, so redirects no longer flush or retarget.
  assign redirect_eff = redirect && (state_q != ST_ERR);
  assign credit       = count < CW'(DEPTH);
  assign deq_valid    = (count != '0) && !redirect_eff;
  assign pop          = deq_valid && bus.deq_ready;
  assign count_after  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  // Next-state, PC update and read-port outputs.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    rd          = 1'b0;
    addr        = fetch_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect_eff) begin
          fetch_pc_d = redirect_pc;
          // Buffer is emptied this edge, so credit is guaranteed.
          state_d    = halt ? ST_IDLE : ST_WAIT;
        end else if (credit && !halt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rd = 1'b1;
        if (redirect_eff) begin
          fetch_pc_d = redirect_pc;
          if (bus.imem_done) begin
            state_d = ST_IDLE;
          end else begin
            // Keep the request address stable while the stale read finishes.
            drop_addr_d = fetch_pc_q;
            state_d     = ST_DROP;
          end
        end else if (bus.imem_done) begin
          if (bus.imem_err) begin
            state_d = ST_ERR;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + WIDTH'(PC_INC);
            state_d    = ((count_after < (CW+1)'(DEPTH)) && !halt) ? ST_WAIT : ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        rd   = 1'b1;
        addr = drop_addr_q;
        if (redirect_eff) fetch_pc_d = redirect_pc;
        if (bus.imem_done) state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, fetch PC and held drop address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  fetch_fifo #(
    .DW   (2*WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_eff),
    .push     (push),
    .push_data({bus.imem_rdata, fetch_pc_q + WIDTH'(PC_INC)}),
    .pop      (pop),
    .head_data(head_data),
    .count    (count)
  );

  assign bus.imem_rd    = rd;
  assign bus.imem_addr  = addr;
  assign bus.deq_valid  = deq_valid;
  assign bus.deq_inst   = deq_valid ? head_data[2*WIDTH-1:WIDTH] : NOP;
  assign bus.deq_inc_pc = head_data[WIDTH-1:0];
  assign occupancy      = count;
  assign err            = (state_q == ST_ERR);

endmodule

// File: tb/tb_fetch_prefetch_buf.sv
// Randomised + directed bench for fetch_prefetch_buf against a queue-based model.
module tb_fetch_prefetch_buf;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [2:0]  occupancy;
  logic        err;

  fetch_prefetch_buf_if #(.WIDTH(16)) bus ();

  fetch_prefetch_buf #(
    .WIDTH   (16),
    .DEPTH   (DEPTH),
    .RESET_PC(16'h0000),
    .NOP     (16'h0800)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .bus        (bus),
    .occupancy  (occupancy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a queue of {inst, pc+2} plus request bookkeeping.
  logic [31:0] mq[$];
  bit          m_busy;   // a read is outstanding
  bit          m_drop;   // its response is to be thrown away
  bit          m_err;
  logic [15:0] m_pc;
  logic [15:0] m_hold;
  int          m_pushes;
  logic [15:0] pop_log[$];

  int wait_cnt  = -1;
  int lat_fixed = 1;

  // Last sampled DUT outputs, for directed literal checks.
  bit          s_rd, s_valid, s_err;
  logic [15:0] s_addr;
  int          s_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_drop = 0; m_err = 0;
    m_pc = 16'h0000; m_hold = 16'h0000;
    wait_cnt = -1;
  endtask

  // Assert reset, check the reset values literally, release on a negedge.
  task automatic do_reset();
    redirect = 0; redirect_pc = '0; halt = 0;
    bus.deq_ready = 0; bus.imem_done = 0; bus.imem_err = 0; bus.imem_rdata = '0;
    rst = 0;
    #1;
    chk("rst_rd",    32'(bus.imem_rd),   32'h0);
    chk("rst_valid", 32'(bus.deq_valid), 32'h0);
    chk("rst_inst",  32'(bus.deq_inst),  32'h0800);
    chk("rst_occ",   32'(occupancy),     32'h0);
    chk("rst_err",   32'(err),           32'h0);
    chk("rst_addr",  32'(bus.imem_addr), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  // One cycle: drive inputs at the negedge, compare, advance the model.
  // fdone: -1 let the memory responder decide, 0/1 force imem_done.
  task automatic step(input bit red, input logic [15:0] rpc, input bit hlt,
                      input bit rdy, input int fdone, input bit ierr);
    bit          exp_rd, d, r_eff, exp_valid, pop;
    logic [31:0] head;
    logic [15:0] exp_addr, exp_inst, rdat;
    int          n0;
    exp_rd = m_busy && !m_err;
    d = 0;
    if (fdone >= 0) begin
      d = exp_rd && (fdone != 0);
      if (d) wait_cnt = -1;
    end else if (exp_rd) begin
      if (wait_cnt < 0) wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      d = (wait_cnt == 0);
      if (d) wait_cnt = -1;
      else   wait_cnt--;
    end
    rdat = 16'($urandom);
    redirect = red; redirect_pc = rpc; halt = hlt;
    bus.deq_ready = rdy; bus.imem_done = d; bus.imem_err = ierr; bus.imem_rdata = rdat;
    #1;
    r_eff     = red && !m_err;
    exp_valid = (mq.size() > 0) && !r_eff;
    head      = (mq.size() > 0) ? mq[0] : 32'h0;
    exp_inst  = exp_valid ? head[31:16] : 16'h0800;
    exp_addr  = m_drop ? m_hold : m_pc;
    chk("imem_rd",   32'(bus.imem_rd),   32'(exp_rd));
    chk("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
    chk("deq_valid", 32'(bus.deq_valid), 32'(exp_valid));
    chk("deq_inst",  32'(bus.deq_inst),  32'(exp_inst));
    if (exp_valid) chk("deq_inc_pc", 32'(bus.deq_inc_pc), 32'(head[15:0]));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("err",       32'(err),       32'(m_err));
    s_rd = bus.imem_rd; s_addr = bus.imem_addr; s_valid = bus.deq_valid;
    s_occ = int'(occupancy); s_err = err;

    n0  = mq.size();
    pop = exp_valid && rdy;
    if (pop) begin
      pop_log.push_back(head[15:0]);
      void'(mq.pop_front());
    end
    if (m_err) begin
      // frozen; only draining happens
    end else if (r_eff) begin
      mq.delete();
      if (m_drop) begin
        if (d) begin m_busy = 0; m_drop = 0; end
      end else if (m_busy) begin
        if (d) m_busy = 0;
        else begin m_drop = 1; m_hold = m_pc; end
      end else begin
        m_busy = !hlt;
      end
      m_pc = rpc;
    end else if (m_drop) begin
      if (d) begin m_busy = 0; m_drop = 0; end
    end else if (m_busy) begin
      if (d) begin
        if (ierr) begin
          m_err = 1; m_busy = 0;
        end else begin
          mq.push_back({rdat, m_pc + 16'd2});
          m_pushes++;
          m_pc   = m_pc + 16'd2;
          m_busy = (mq.size() < DEPTH) && !hlt;
        end
      end
    end else begin
      m_busy = (n0 < DEPTH) && !hlt;
    end
    @(negedge clk);
  endtask

  int k;
  int err_age;

  initial begin
    // 1: streaming fetch from reset
    do_reset();
    pop_log.delete();
    lat_fixed = 1;
    repeat (10) step(0, 16'h0, 0, 1, -1, 0);
    chk("t1_npops", 32'(pop_log.size() >= 3), 32'h1);
    if (pop_log.size() >= 3) begin
      chk("t1_pc0", 32'(pop_log[0]), 32'h2);
      chk("t1_pc1", 32'(pop_log[1]), 32'h4);
      chk("t1_pc2", 32'(pop_log[2]), 32'h6);
    end

    // 2: decode stalled until the buffer fills, then resume
    do_reset();
    m_pushes = 0;
    repeat (20) step(0, 16'h0, 0, 0, -1, 0);
    chk("t2_pushes", 32'(m_pushes), 32'd4);
    chk("t2_occ",    32'(s_occ),    32'd4);
    chk("t2_rd",     32'(s_rd),     32'd0);
    k = 0;
    do begin step(0, 16'h0, 0, 1, -1, 0); k++; end while (!s_rd && k < 10);
    chk("t2_resume_rd",   32'(s_rd),   32'd1);
    chk("t2_resume_addr", 32'(s_addr), 32'h0008);

    // 3: redirect while a read is outstanding; response arrives 3 cycles later
    do_reset();
    step(0, 16'h0, 0, 1, 0, 0);                 // IDLE -> WAIT
    step(1, 16'h0040, 0, 1, 0, 0);              // redirect, no done
    step(0, 16'h0, 0, 1, 0, 0);
    step(0, 16'h0, 0, 1, 0, 0);
    chk("t3_drop_addr", 32'(s_addr), 32'h0000);
    step(0, 16'h0, 0, 1, 1, 0);                 // stale response
    k = 0;
    do begin step(0, 16'h0, 0, 1, 0, 0); k++; end while (!s_rd && k < 5);
    chk("t3_rd",   32'(s_rd),   32'd1);
    chk("t3_addr", 32'(s_addr), 32'h0040);
    chk("t3_occ",  32'(s_occ),  32'd0);

    // 4: redirect coinciding with imem_done and a pop
    do_reset();
    lat_fixed = 1;
    k = 0;
    do begin step(0, 16'h0, 0, 0, -1, 0); k++; end while (!(mq.size() >= 2 && m_busy) && k < 20);
    step(1, 16'h0100, 0, 1, 1, 0);
    chk("t4_valid", 32'(s_valid), 32'd0);
    step(0, 16'h0, 0, 1, 0, 0);
    chk("t4_occ", 32'(s_occ), 32'd0);

    // 5: memory error is sticky, buffer drains, reset clears it
    do_reset();
    k = 0;
    do begin step(0, 16'h0, 0, 0, -1, 0); k++; end while (!(mq.size() >= 2 && m_busy) && k < 20);
    step(0, 16'h0, 0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0);
    chk("t5_err", 32'(s_err), 32'd1);
    chk("t5_rd",  32'(s_rd),  32'd0);
    pop_log.delete();
    repeat (6) step(0, 16'h0, 0, 1, -1, 0);
    chk("t5_drained", 32'(pop_log.size()), 32'd2);
    chk("t5_err_hold", 32'(s_err), 32'd1);
    do_reset();
    step(0, 16'h0, 0, 1, -1, 0);
    chk("t5_err_clr", 32'(s_err), 32'd0);

    // 6a: halt mid-stream lets the outstanding read finish, then stops
    do_reset();
    lat_fixed = 2;
    step(0, 16'h0, 0, 1, -1, 0);
    m_pushes = 0;
    repeat (10) step(0, 16'h0, 1, 1, -1, 0);
    chk("t6_halt_pushes", 32'(m_pushes), 32'd1);
    chk("t6_halt_rd",     32'(s_rd),     32'd0);

    // 6b: PC wraps from 16'hFFFE to 16'h0000 without error
    do_reset();
    lat_fixed = 1;
    pop_log.delete();
    step(1, 16'hFFFE, 0, 1, -1, 0);
    k = 0;
    while (pop_log.size() < 2 && k < 20) begin step(0, 16'h0, 0, 1, -1, 0); k++; end
    chk("t6_wrap_npops", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) begin
      chk("t6_wrap_pc0", 32'(pop_log[0]), 32'h0000);
      chk("t6_wrap_pc1", 32'(pop_log[1]), 32'h0002);
    end
    chk("t6_wrap_err", 32'(s_err), 32'd0);

    // Random traffic against the model
    do_reset();
    lat_fixed = -1;
    err_age = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 5, 16'($urandom) & 16'hFFFE,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60,
           -1, $urandom_range(0, 199) < 2);
      if (m_err) err_age++;
      if (err_age > 8) begin
        do_reset();
        err_age = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
